// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Optional anti-starvation logic is enabled with MEMORY_ARBITER_ANTISTARVE_EN.
package memory_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        OWNER_FETCH,
        OWNER_DATA
    } arb_owner_t;

    // funct3 encoding of a full-word load; fetches always use it
    localparam logic [2:0] LOAD_WORD = 3'b010;

endpackage

// File: rtl/memory_arbiter_select.sv
// Combinational winner pick between fetch and data requesters.
// With MEMORY_ARBITER_ANTISTARVE_EN defined, a starve counter forces fetch after STARVE_LIMIT data wins.
module memory_arbiter_select
    import memory_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Enable,
    input  logic i_FetchReq,
    input  logic i_DataReq,
    output logic o_FetchWin,
    output logic o_DataWin
);

`ifdef MEMORY_ARBITER_ANTISTARVE_EN
    localparam int STARVE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_Starve;
    logic                w_Force;

    assign w_Force = (r_Starve >= STARVE_W'(STARVE_LIMIT));

    always_comb begin
        o_DataWin  = i_Enable & i_DataReq & ~(i_FetchReq & w_Force);
        o_FetchWin = i_Enable & i_FetchReq & ~o_DataWin;
    end

    // Saturates at the limit: once forced, data cannot win a contended pick
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Starve <= '0;
        end else if (o_FetchWin) begin
            r_Starve <= '0;
        end else if (o_DataWin && i_FetchReq && !w_Force) begin
            r_Starve <= r_Starve + STARVE_W'(1);
        end
    end
`else
    logic w_unused;

    assign w_unused   = &{1'b0, i_Clock, i_Reset, (STARVE_LIMIT > 0)};
    assign o_DataWin  = i_Enable & i_DataReq;
    assign o_FetchWin = i_Enable & i_FetchReq & ~i_DataReq;
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Optional fetch anti-starvation: define MEMORY_ARBITER_ANTISTARVE_EN.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_FetchReq,
    input  logic [31:0] i_FetchAddress,
    output logic        o_FetchGrant,
    output logic        o_FetchValid,
    output logic [31:0] o_FetchData,
    input  logic        i_DataReq,
    input  logic        i_DataWrite,
    input  logic [31:0] i_DataAddress,
    input  logic [31:0] i_DataIn,
    input  logic [2:0]  i_DataMode,
    output logic        o_DataGrant,
    output logic        o_DataValid,
    output logic [31:0] o_DataOut,
    output logic        o_DataFault,
    output logic        o_MemReadEnable,
    output logic        o_MemWriteEnable,
    output logic [31:0] o_MemAddress,
    output logic [31:0] o_MemDataIn,
    output logic [2:0]  o_MemMode,
    input  logic [31:0] i_MemDataOut,
    input  logic        i_MemMisalignedAccess,
    output logic        o_Busy
);

    localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

    generate
        if (MEM_LATENCY < 1) begin : g_latency_check
            $error("memory_arbiter: MEM_LATENCY must be >= 1");
        end
    endgenerate

    arb_state_t       r_State;
    arb_state_t       w_NextState;
    arb_owner_t       r_Owner;
    logic [CNT_W-1:0] r_Count;
    logic             r_Write;
    logic             r_FaultPend;
    logic             r_FetchValid;
    logic             r_DataValid;
    logic             r_DataFault;
    logic [31:0]      r_FetchData;
    logic [31:0]      r_DataOut;
    logic             w_Idle;
    logic             w_FetchWin;
    logic             w_DataWin;
    logic             w_Accept;
    logic             w_Capture;

    // Reset also masks the combinational grant/strobe paths
    assign w_Idle    = (r_State == ARB_IDLE) && !i_Reset;
    assign w_Accept  = w_FetchWin | w_DataWin;
    assign w_Capture = (r_State == ARB_WAIT) && (r_Count == CNT_W'(1));

    memory_arbiter_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Enable   (w_Idle),
        .i_FetchReq (i_FetchReq),
        .i_DataReq  (i_DataReq),
        .o_FetchWin (w_FetchWin),
        .o_DataWin  (w_DataWin)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State <= ARB_IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            ARB_IDLE: if (w_Accept)  w_NextState = ARB_WAIT;
            ARB_WAIT: if (w_Capture) w_NextState = ARB_IDLE;
            default:                 w_NextState = ARB_IDLE;
        endcase
    end

    always_comb begin
        o_MemReadEnable  = 1'b0;
        o_MemWriteEnable = 1'b0;
        o_MemAddress     = 32'd0;
        o_MemDataIn      = 32'd0;
        o_MemMode        = 3'd0;
        if (w_FetchWin) begin
            o_MemReadEnable = 1'b1;
            o_MemAddress    = i_FetchAddress;
            o_MemMode       = LOAD_WORD;
        end else if (w_DataWin) begin
            o_MemReadEnable  = !i_DataWrite;
            o_MemWriteEnable = i_DataWrite;
            o_MemAddress     = i_DataAddress;
            o_MemDataIn      = i_DataIn;
            o_MemMode        = i_DataMode;
        end
    end

    assign o_FetchGrant = w_FetchWin;
    assign o_DataGrant  = w_DataWin;
    assign o_Busy       = (r_State == ARB_WAIT);
    assign o_FetchValid = r_FetchValid;
    assign o_FetchData  = r_FetchData;
    assign o_DataValid  = r_DataValid;
    assign o_DataOut    = r_DataOut;
    assign o_DataFault  = r_DataFault;

    // Access bookkeeping and response registers; responses hold until the next one
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Owner      <= OWNER_FETCH;
            r_Count      <= '0;
            r_Write      <= 1'b0;
            r_FaultPend  <= 1'b0;
            r_FetchValid <= 1'b0;
            r_DataValid  <= 1'b0;
            r_DataFault  <= 1'b0;
            r_FetchData  <= 32'd0;
            r_DataOut    <= 32'd0;
        end else begin
            r_FetchValid <= 1'b0;
            r_DataValid  <= 1'b0;
            if (w_Accept) begin
                r_Owner     <= w_DataWin ? OWNER_DATA : OWNER_FETCH;
                r_Write     <= w_DataWin & i_DataWrite;
                r_FaultPend <= w_DataWin & i_MemMisalignedAccess;
                r_Count     <= CNT_W'(MEM_LATENCY);
            end else if (r_State == ARB_WAIT) begin
                r_Count <= r_Count - CNT_W'(1);
            end
            if (w_Capture) begin
                if (r_Owner == OWNER_FETCH) begin
                    r_FetchValid <= 1'b1;
                    r_FetchData  <= i_MemDataOut;
                end else begin
                    r_DataValid <= 1'b1;
                    r_DataFault <= r_FaultPend;
                    if (!r_Write) begin
                        r_DataOut <= i_MemDataOut;
                    end
                end
            end
        end
    end

endmodule
